// File: rtl/lif_pkg.sv
// Shared types, sizing constants and saturating add for the LIF core sequencer.
package lif_pkg;

  localparam int unsigned N          = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned SPK_W      = 8;
  localparam int unsigned WT_W       = 8;
  localparam int unsigned POT_W      = 16;
  localparam int unsigned LEAK_SHIFT = 4;
  localparam int unsigned STAT_W     = 16;
  localparam logic [POT_W-1:0] VTH   = 16'h0100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    ACCUM   = 3'd2,
    LEAK_RD = 3'd3,
    LEAK_WR = 3'd4
  } state_t;

  // Signed potential plus sign-extended weight, clamped to the potential range
  function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0] a,
                                               input logic [WT_W-1:0]  b);
    logic [POT_W:0] sum;
    sum = {a[POT_W-1], a} + {{(POT_W+1-WT_W){b[WT_W-1]}}, b};
    if (sum[POT_W] != sum[POT_W-1])
      sat_add = sum[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    else
      sat_add = sum[POT_W-1:0];
  endfunction

endpackage

// File: rtl/lif_leak_fire.sv
// Combinational leak, threshold compare and post-fire reset value for one neuron.
module lif_leak_fire
  import lif_pkg::*;
(
  input  logic [POT_W-1:0] v,
  output logic [POT_W-1:0] v_wr,
  output logic             fire
);

  logic signed [POT_W-1:0] v_s;
  logic signed [POT_W-1:0] v_leak;

  assign v_s    = $signed(v);
  assign v_leak = v_s - (v_s >>> LEAK_SHIFT);
  assign fire   = (v_leak >= $signed(VTH));
  assign v_wr   = fire ? '0 : v_leak;

endmodule

// File: rtl/lif_core_sched.sv
// Spike-accumulate / leak-fire sequencer for one LIF neuron core.
// Optional LIF_SCHED_STATS_EN builds saturating drop/fire counters.
module lif_core_sched
  import lif_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_core,
  input  logic              step_i,
  input  logic              fifo_empty_i,
  input  logic [SPK_W-1:0]  fifo_data_i,
  output logic              fifo_rd_o,
  output logic [AW-1:0]     w_row_o,
  output logic [AW-1:0]     w_col_o,
  input  logic [WT_W-1:0]   w_data_i,
  output logic [AW-1:0]     pot_raddr_o,
  input  logic [POT_W-1:0]  pot_rdata_i,
  output logic              pot_we_o,
  output logic [AW-1:0]     pot_waddr_o,
  output logic [POT_W-1:0]  pot_wdata_o,
  output logic              spk_valid_o,
  output logic [AW-1:0]     spk_idx_o,
  input  logic              spk_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [STAT_W-1:0] stat_drop_o,
  output logic [STAT_W-1:0] stat_fire_o
);

  localparam logic [AW:0] CNT_ACC_LAST  = (AW+1)'(N);
  localparam logic [AW:0] CNT_LEAK_LAST = (AW+1)'(N - 1);

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic [SPK_W-1:0] idx_q, idx_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             spk_valid_q, spk_valid_d;
  logic [AW-1:0]    spk_idx_q, spk_idx_d;
  logic             done_q, done_d;

  logic             we_c;
  logic [AW-1:0]    waddr_c;
  logic [POT_W-1:0] wdata_c;
  logic [POT_W-1:0] leak_v;
  logic             leak_fire;
  logic             start_pop, spk_free, idx_bad, wr_go;

  lif_leak_fire u_leak_fire (
    .v    (pot_rdata_i),
    .v_wr (leak_v),
    .fire (leak_fire)
  );

  assign start_pop = en_core && !fifo_empty_i;
  assign spk_free  = !spk_valid_q || spk_ready_i;
  assign idx_bad   = (idx_q >= SPK_W'(N));
  // A firing neuron may only commit once the spike register can take it
  assign wr_go     = (state_q == LEAK_WR) && (!leak_fire || spk_free);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fifo_rd_q   <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      spk_valid_q <= spk_valid_d;
      spk_idx_q   <= spk_idx_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q | step_i;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fifo_rd_d   = 1'b0;
    spk_valid_d = spk_valid_q && !spk_ready_i;
    spk_idx_d   = spk_idx_q;
    done_d      = 1'b0;
    we_c        = 1'b0;
    waddr_c     = '0;
    wdata_c     = '0;
    case (state_q)
      IDLE: begin
        if (start_pop) begin
          state_d   = POP;
          fifo_rd_d = 1'b1;
          idx_d     = fifo_data_i;
        end else if (en_core && step_q) begin
          // Steps seen from here on belong to the next sweep
          state_d = LEAK_RD;
          step_d  = step_i;
          cnt_d   = '0;
        end
      end
      POP: begin
        cnt_d   = '0;
        state_d = idx_bad ? IDLE : ACCUM;
      end
      ACCUM: begin
        if (cnt_q != '0) begin
          we_c    = 1'b1;
          waddr_c = AW'(cnt_q - (AW+1)'(1));
          wdata_c = sat_add(pot_rdata_i, w_data_i);
        end
        if (cnt_q == CNT_ACC_LAST) begin
          // Chain straight into the next pop so back-to-back spikes cost N+2
          cnt_d = '0;
          if (start_pop) begin
            state_d   = POP;
            fifo_rd_d = 1'b1;
            idx_d     = fifo_data_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + (AW+1)'(1);
        end
      end
      LEAK_RD: state_d = LEAK_WR;
      LEAK_WR: begin
        if (wr_go) begin
          we_c    = 1'b1;
          waddr_c = cnt_q[AW-1:0];
          wdata_c = leak_v;
          if (leak_fire) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = cnt_q[AW-1:0];
          end
          if (cnt_q == CNT_LEAK_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = LEAK_RD;
            cnt_d   = cnt_q + (AW+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_o   = fifo_rd_q;
  assign w_row_o     = idx_q[AW-1:0];
  assign w_col_o     = cnt_q[AW-1:0];
  assign pot_raddr_o = cnt_q[AW-1:0];
  assign pot_we_o    = we_c;
  assign pot_waddr_o = waddr_c;
  assign pot_wdata_o = wdata_c;
  assign spk_valid_o = spk_valid_q;
  assign spk_idx_o   = spk_idx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

`ifdef LIF_SCHED_STATS_EN
  logic [STAT_W-1:0] drop_q, fire_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q <= '0;
      fire_q <= '0;
    end else begin
      if ((state_q == POP) && idx_bad && (drop_q != '1))
        drop_q <= drop_q + STAT_W'(1);
      if (wr_go && leak_fire && (fire_q != '1))
        fire_q <= fire_q + STAT_W'(1);
    end
  end

  assign stat_drop_o = drop_q;
  assign stat_fire_o = fire_q;
`else
  assign stat_drop_o = '0;
  assign stat_fire_o = '0;
`endif

endmodule

// File: doc/lif_core_sched.md
Name: lif_core_sched

Overview:
- Sequencer for one LIF neuron core.
- Pops presynaptic spike indices from the core's input spike FIFO and walks the matching weight row into the membrane-potential memory, one neuron per cycle.
- On a timestep boundary it runs a leak/threshold/reset sweep over all neurons and emits output spikes over a valid/ready port.
- Sits between the input queue, the weight memory, the potential memory and the output spike path inside n_core.

Parameters:
- N, 32, number of neurons (rows/cols of the weight matrix).
- AW, 5, neuron index width, equal to clog2(N).
- SPK_W, 8, width of spike index words in the input FIFO.
- WT_W, 8, signed weight width.
- POT_W, 16, signed membrane potential width.
- LEAK_SHIFT, 4, leak is v - (v >>> LEAK_SHIFT).
- VTH, 16'sh0100, firing threshold (signed, POT_W bits).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- en_core  in  1  core enable, sampled only in IDLE
- step_i  in  1  timestep-boundary pulse, latched sticky
- fifo_empty_i  in  1  input FIFO empty
- fifo_data_i  in  SPK_W  FIFO head word (first-word fall-through)
- fifo_rd_o  out  1  pop strobe
- w_row_o  out  AW  weight row (presynaptic index)
- w_col_o  out  AW  weight column (postsynaptic index)
- w_data_i  in  WT_W  weight read data, valid 1 cycle after address
- pot_raddr_o  out  AW  potential read address
- pot_rdata_i  in  POT_W  potential read data, valid 1 cycle after address
- pot_we_o  out  1  potential write enable
- pot_waddr_o  out  AW  potential write address
- pot_wdata_o  out  POT_W  potential write data
- spk_valid_o  out  1  output spike valid
- spk_idx_o  out  AW  output spike neuron index
- spk_ready_i  in  1  output spike accepted
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at the end of the LEAK sweep
- stat_drop_o  out  16  dropped-spike count (see Optional Feature)
- stat_fire_o  out  16  fired-spike count (see Optional Feature)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; step pending cleared; all outputs 0.
- Potential memory is dual-port: one read port plus one independent write port.
- IDLE:
  - if en_core and !fifo_empty_i: assert fifo_rd_o for 1 cycle and capture fifo_data_i.
  - else if en_core and step pending: go to LEAK.
  - FIFO work has priority over step.
- Captured index >= N: dropped; pop still happens; back to IDLE next cycle.
- Valid index goes to ACCUM:
  - cycle k issues w_row=idx, w_col=k and pot_raddr=k, for k=0..N-1.
  - cycle k+1 writes pot_waddr=k with pot_wdata = sat(pot_rdata_i + sext(w_data_i)).
  - Saturate to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - Read and write addresses never collide, so there is no hazard.
  - Takes N+1 cycles, then returns to IDLE.
  - Consecutive spikes cost N+2 cycles each.
- LEAK: for each neuron n, 2 cycles.
  - RD: pot_raddr=n.
  - WR: compute v' = v - (v >>> LEAK_SHIFT).
  - If v' >= VTH: write 0 and load the spike register with idx=n.
  - Otherwise write v'.
- Spike register:
  - spk_valid_o stays high until spk_ready_i; transfer happens on valid&&ready.
  - If WR needs to fire while the register is still occupied, WR stalls with no write until it frees.
  - A same-cycle accept plus reload is allowed.
- After n=N-1: pulse done_o, clear step pending, go to IDLE. step_i arriving during LEAK stays pending for the next sweep.
- step_i arriving during ACCUM is latched; LEAK starts only after the FIFO is drained.
- en_core dropping mid-operation: the current spike or sweep completes, then the block holds in IDLE.
- fifo_rd_o is never asserted while fifo_empty_i=1.

Optional Feature:
- Macro LIF_SCHED_STATS_EN.
- Defined:
  - stat_drop_o counts dropped indices (>= N).
  - stat_fire_o counts spikes loaded into the spike register.
  - Both 16-bit, saturate at 16'hFFFF, cleared by rst_i.
- Undefined: both ports driven constant 0; no counter flops are built.

Decomposition:
- Package lif_pkg holds:
  - the state enum (IDLE, POP, ACCUM, LEAK_RD, LEAK_WR);
  - the N, AW, WT_W, POT_W defaults;
  - a sat_add function.
- Sub-module lif_leak_fire: combinational leak, threshold compare and reset-value select. Instantiated once.

Test Plan:
- Weights diag 8'h10 else 8'h05, all potentials 0. Push idx 3 -> pot[3]=16, every other pot=5; exactly 32 writes; busy_o low after 33 cycles.
- Push idx 40 -> one pop, no pot writes; stat_drop_o=1 when the macro is on.
- Preload pot[7]=16'sh0120, others 0, pulse step_i -> pot[7] leaks to 0x10E, which fires; spk_idx_o=7; pot[7]=0. done_o pulses once after 64+ cycles.
- Same as above with spk_ready_i held low 10 cycles, and pot[7] and pot[9] both above VTH -> sweep stalls at n=9; spikes 7 then 9 are delivered in order with none lost.
- pot[0]=16'sh7FFC, weight 8'h10 row 0 -> pot[0] saturates to 16'sh7FFF.
- Assert rst_i mid-ACCUM -> all outputs 0 immediately; IDLE on the next edge; step pending cleared.
